// File: rtl/pin_deser_pkg.sv
// Shared types and constants for the oversampling pin deserialiser.
// Lane FSM encoding and the default frame alignment word.
package pin_deser_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } lane_state_t;

  localparam logic [7:0] SYNC_DEF = 8'hA5;

endpackage

// File: rtl/pin_deser_lane.sv
// One serial lane: synchroniser, edge-aligned phase counter, bit sampler,
// and HUNT/LOCK framing of W-bit words.
module pin_deser_lane
  import pin_deser_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned OSR    = 4,
  parameter logic [W-1:0] SYNC  = W'(SYNC_DEF),
  parameter int unsigned MAXRUN = 16,
  localparam int unsigned PW    = $clog2(OSR)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pin_i,
  output logic [W-1:0]  word_o,
  output logic          str_o,
  output logic [PW-1:0] ptime_o,
  output logic          locked_o
);

  localparam int unsigned BW = $clog2(W);
  localparam int unsigned RW = $clog2(MAXRUN + 1);
  localparam logic [PW-1:0] PH_MID = PW'(OSR / 2);
  localparam logic [PW-1:0] PH_MAX = PW'(OSR - 1);
  localparam logic [BW-1:0] B_MAX  = BW'(W - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAXRUN);

  logic s1_q, s2_q, s3_q;
  logic edg, smp, run_hit;

  lane_state_t   state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [PW-1:0] ptime_q, ptime_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [RW-1:0] run_q, run_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  word_q, word_d;
  logic          str_q, str_d;
  logic          locked_q;

  // Edge re-aligns the phase; a bit is taken mid-period only.
  assign edg = s2_q ^ s3_q;
  assign smp = !edg && (ph_q == PH_MID);

  always_comb begin
    ph_d    = (ph_q == PH_MAX) ? '0 : ph_q + 1'b1;
    ptime_d = ptime_q;
    run_d   = run_q;
    shift_d = shift_q;
    if (edg) begin
      ph_d    = '0;
      ptime_d = ph_q;
      run_d   = '0;
    end else if (smp) begin
      shift_d = {shift_q[W-2:0], s2_q};
      if (run_q != R_MAX) run_d = run_q + 1'b1;
    end
  end

  assign run_hit = (run_d == R_MAX);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    str_d   = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (smp && shift_d == SYNC) begin
          state_d = LOCK;
          bcnt_d  = '0;
        end
      end
      LOCK: begin
        // A stuck line drops lock and abandons the partial word.
        if (run_hit) begin
          state_d = HUNT;
          bcnt_d  = '0;
        end else if (smp) begin
          if (bcnt_q == B_MAX) begin
            word_d = shift_d;
            str_d  = 1'b1;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= HUNT;
      ph_q     <= '0;
      ptime_q  <= '0;
      bcnt_q   <= '0;
      run_q    <= '0;
      shift_q  <= '0;
      word_q   <= '0;
      str_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      s1_q     <= pin_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      ph_q     <= ph_d;
      ptime_q  <= ptime_d;
      bcnt_q   <= bcnt_d;
      run_q    <= run_d;
      shift_q  <= shift_d;
      word_q   <= word_d;
      str_q    <= str_d;
      locked_q <= (state_d == LOCK);
    end
  end

  assign word_o   = word_q;
  assign str_o    = str_q;
  assign ptime_o  = ptime_q;
  assign locked_o = locked_q;

endmodule

// File: rtl/pin_deser.sv
// Multi-lane oversampling deserialiser: NCH independent lanes packed
// side by side on the output buses.
module pin_deser
  import pin_deser_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned W      = 8,
  parameter int unsigned OSR    = 4,
  parameter logic [W-1:0] SYNC  = W'(SYNC_DEF),
  parameter int unsigned MAXRUN = 16,
  localparam int unsigned PW    = $clog2(OSR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    pin_in,
  output logic [NCH*W-1:0]  word_out,
  output logic [NCH-1:0]    str,
  output logic [NCH*PW-1:0] ptime,
  output logic [NCH-1:0]    locked
);

  for (genvar n = 0; n < NCH; n++) begin : g_lane
    pin_deser_lane #(
      .W      (W),
      .OSR    (OSR),
      .SYNC   (SYNC),
      .MAXRUN (MAXRUN)
    ) u_lane (
      .clk_i    (clk),
      .rst_i    (rst),
      .pin_i    (pin_in[n]),
      .word_o   (word_out[n*W +: W]),
      .str_o    (str[n]),
      .ptime_o  (ptime[n*PW +: PW]),
      .locked_o (locked[n])
    );
  end

endmodule

// File: doc/pin_deser.md
PIN_DESER -- requirements
Module: pin_deser

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent serial lanes.
REQ-002 SHALL have parameter W, default 8: deserialised word width in bits.
REQ-003 SHALL have parameter OSR, default 4, legal range 3..16: clk cycles per serial bit.
REQ-004 SHALL have parameter SYNC, default 8'hA5, W bits wide: frame alignment pattern.
REQ-005 SHALL have parameter MAXRUN, default 16: bits without an edge before lock is lost.
REQ-006 SHALL derive localparam PW = $clog2(OSR): phase field width.
REQ-007 SHALL use one clock and an asynchronous active-high reset.
REQ-008 Port clk, input, 1 bit: sole clock (oversampling clock).
REQ-009 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 Port pin_in, input, NCH bits: asynchronous serial inputs, one per lane, MSB-first.
REQ-011 Port word_out, output, NCH*W bits: lane n word at [n*W +: W].
REQ-012 Port str, output, NCH bits: one-cycle word strobe per lane.
REQ-013 Port ptime, output, NCH*PW bits: lane n phase value captured at the last edge.
REQ-014 Port locked, output, NCH bits: high while lane n is in the LOCK state.

Function
REQ-015 Each lane SHALL pass pin_in through a 2-FF synchroniser, then a third flop for edge detection.
REQ-016 An edge SHALL be flagged when the synchronised sample differs from its previous value.
REQ-017 Phase counter ph SHALL count 0..OSR-1 and wrap to 0.
REQ-018 On an edge, ph SHALL load 0 and ptime SHALL capture the pre-edge ph value.
REQ-019 A bit SHALL be sampled in the cycle where ph == OSR/2 (integer division) and no edge is flagged.
- An edge always takes priority.
- No bit is sampled in an edge cycle.
REQ-020 Sampled bits SHALL shift MSB-first into a W-bit shift register.
REQ-021 FSM states SHALL be HUNT and LOCK.
REQ-022 HUNT: after each sampled bit, if shift register == SYNC, go to LOCK and clear the bit counter.
- The sync word itself produces no str.
REQ-023 LOCK: the bit counter SHALL count 0..W-1.
- When the W-th bit is sampled, word_out SHALL update and str SHALL pulse high in the next cycle (latency 1 clk from the last bit sample).
REQ-024 In LOCK, a SYNC-valued word SHALL be delivered as ordinary data; there is no re-alignment.
REQ-025 A run counter SHALL count sampled bits since the last edge and saturate at MAXRUN.
- Reaching MAXRUN in LOCK SHALL force HUNT in the next cycle.
- Any partial word SHALL be discarded without str.
REQ-026 locked SHALL equal (state == LOCK), registered.
REQ-027 word_out SHALL hold its last value between strobes.
REQ-028 Lanes SHALL be fully independent; an event on one lane SHALL NOT affect another.

Reset
REQ-029 While rst is high, all lanes SHALL be held in the reset state:
- state = HUNT; ph, bit counter, run counter and shift register = 0.
- Synchroniser flops = 0.
- Outputs: word_out = 0, str = 0, ptime = 0, locked = 0.
REQ-030 Assertion of rst mid-word SHALL take effect asynchronously.
- No str SHALL follow the release of rst until a fresh SYNC is found.

Structure
REQ-031 Package pin_deser_pkg SHALL hold the lane_state_t enum (HUNT, LOCK) and a default SYNC constant.
REQ-032 Per-lane logic SHALL live in sub-module pin_deser_lane.
- pin_deser SHALL generate NCH instances of it and pack their outputs.

Verification (NCH=2, W=8, OSR=4, SYNC=8'hA5)
REQ-033 Lane0 sends A5 then 3C at 4 clk/bit -> word_out[7:0] = 8'h3C, str[0] high exactly one cycle, locked[0] = 1.
REQ-034 Lane0 sends 3C,5A with no sync -> str[0] never asserts, locked[0] = 0.
REQ-035 Lock lane0, then hold pin_in[0] low for 16 bit times -> locked[0] falls, no str for the partial word.
REQ-036 After lock, one bit stretched to 5 clk -> ptime shows 0 (pre-edge ph value after the stretched bit), following word still correct.
REQ-037 Assert rst mid-word after lock -> all outputs 0 immediately; after release no str until A5 is resent.
REQ-038 Lane1 sends A5,C3 while lane0 is idle -> only str[1] pulses, word_out[15:8] = 8'hC3, locked = 2'b10.
